// File: rtl/img_core_pkg.sv
// Shared constants, state encoding and helpers for the blurring core frame sequencer.
// Geometry is fixed here; the sequencer and credit counter derive all widths from it.
package img_core_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned IMAGE_WIDTH    = 324;
    localparam int unsigned MAX_HEIGHT     = 1024;
    localparam int unsigned CREDITS        = 8;
    localparam int unsigned LEAD_LINES     = 2;
    localparam int unsigned TIMEOUT_CYCLES = 4096;

    localparam int unsigned WPL        = IMAGE_WIDTH * 8 / DATA_WIDTH;
    localparam int unsigned HEIGHT_W   = $clog2(MAX_HEIGHT + 1);
    localparam int unsigned WORD_W     = $clog2(WPL);
    localparam int unsigned TOTAL_W    = $clog2(MAX_HEIGHT * WPL + 1);
    localparam int unsigned CREDIT_W   = $clog2(CREDITS + 1);
    localparam int unsigned TIMEOUT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // A frame must contain at least one output line and fit the counters.
    function automatic logic height_ok(input logic [HEIGHT_W-1:0] h);
        return (32'(h) > LEAD_LINES) && (32'(h) <= MAX_HEIGHT);
    endfunction

endpackage

// File: rtl/img_credit_counter.sv
// Saturating up/down credit counter for the core output buffer.
// Restore wins over everything; a simultaneous consume and return cancel out.
module img_credit_counter
    import img_core_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = CREDITS,
    parameter int unsigned WIDTH      = CREDIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             consume,
    input  logic             give_back,
    input  logic             restore,
    output logic [WIDTH-1:0] credit
);

    localparam logic [WIDTH-1:0] FULL = WIDTH'(MAX_CREDIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= FULL;
        end else if (restore) begin
            credit <= FULL;
        end else if (consume && !give_back) begin
            if (credit != '0) begin
                credit <= credit - WIDTH'(1);
            end
        end else if (give_back && !consume) begin
            // Returns beyond capacity come from a misbehaving sink; clamp them.
            if (credit < FULL) begin
                credit <= credit + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/img_frame_sequencer.sv
// Frame-level controller: credit-gates DMA input into the blurring core, counts lines/words,
// marks the last output word and raises interrupts. IMG_SEQ_TIMEOUT_EN adds a drain watchdog.
module img_frame_sequencer
    import img_core_pkg::*;
(
    input  logic                axi_clock,
    input  logic                axi_reset,
    input  logic                cfg_start,
    input  logic [HEIGHT_W-1:0] cfg_height,
    input  logic                cfg_abort,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                core_valid,
    input  logic                out_beat,
    output logic                m_last,
    output logic                busy,
    output logic                intr_line,
    output logic                intr_frame,
    output logic                err_cfg,
    output logic                err_overrun,
    output logic [HEIGHT_W-1:0] line_count
`ifdef IMG_SEQ_TIMEOUT_EN
    ,
    output logic                err_timeout
`endif
);

    localparam logic [TOTAL_W-1:0] LEAD_WORDS = TOTAL_W'(LEAD_LINES * WPL);
    localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(WPL - 1);

    seq_state_e          state;
    logic [TOTAL_W-1:0]  in_cnt;
    logic [TOTAL_W-1:0]  out_cnt;
    logic [TOTAL_W-1:0]  in_total;
    logic [TOTAL_W-1:0]  out_total;
    logic [WORD_W-1:0]   word_cnt;
    logic [CREDIT_W-1:0] credit;

    logic counting_c;
    logic kill_c;
    logic timeout_c;
    logic consume_c;
    logic give_back_c;
    logic restore_c;

    // Handshake and marker decode from registered state only.
    always_comb begin
        counting_c  = (state == RUN) || (state == DRAIN);
        s_ready     = (state == RUN) && (in_cnt < in_total) &&
                      ((credit != '0) || (in_cnt < LEAD_WORDS));
        core_valid  = s_valid && s_ready;
        m_last      = counting_c && (out_cnt == out_total - TOTAL_W'(1));
        kill_c      = ((state != IDLE) && cfg_abort) || timeout_c;
        consume_c   = core_valid && (in_cnt >= LEAD_WORDS);
        give_back_c = out_beat && counting_c;
        restore_c   = kill_c || (state == IDLE) || (state == DONE);
    end

    img_credit_counter #(
        .MAX_CREDIT (CREDITS),
        .WIDTH      (CREDIT_W)
    ) u_credit (
        .clk       (axi_clock),
        .rst       (axi_reset),
        .consume   (consume_c),
        .give_back (give_back_c),
        .restore   (restore_c),
        .credit    (credit)
    );

    // Frame FSM with its counters and registered status outputs.
    always_ff @(posedge axi_clock or posedge axi_reset) begin
        if (axi_reset) begin
            state       <= IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            in_total    <= '0;
            out_total   <= '0;
            word_cnt    <= '0;
            line_count  <= '0;
            busy        <= 1'b0;
            intr_line   <= 1'b0;
            intr_frame  <= 1'b0;
            err_cfg     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            intr_line  <= 1'b0;
            intr_frame <= 1'b0;
            if (kill_c) begin
                state      <= IDLE;
                busy       <= 1'b0;
                in_cnt     <= '0;
                out_cnt    <= '0;
                word_cnt   <= '0;
                line_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (out_beat) begin
                            err_overrun <= 1'b1;
                        end
                        if (cfg_start) begin
                            if (height_ok(cfg_height)) begin
                                state      <= RUN;
                                busy       <= 1'b1;
                                in_total   <= TOTAL_W'(cfg_height) * TOTAL_W'(WPL);
                                out_total  <= TOTAL_W'(cfg_height - HEIGHT_W'(LEAD_LINES)) *
                                              TOTAL_W'(WPL);
                                in_cnt     <= '0;
                                out_cnt    <= '0;
                                word_cnt   <= '0;
                                line_count <= '0;
                            end else begin
                                err_cfg <= 1'b1;
                            end
                        end
                    end
                    RUN, DRAIN: begin
                        if (core_valid) begin
                            in_cnt <= in_cnt + TOTAL_W'(1);
                        end
                        if (out_beat) begin
                            out_cnt <= out_cnt + TOTAL_W'(1);
                            if (word_cnt == LAST_WORD) begin
                                word_cnt   <= '0;
                                line_count <= line_count + HEIGHT_W'(1);
                                intr_line  <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + WORD_W'(1);
                            end
                        end
                        if ((state == RUN) && core_valid && (in_cnt == in_total - TOTAL_W'(1))) begin
                            state <= DRAIN;
                        end
                        if ((state == DRAIN) && (out_cnt >= out_total)) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        intr_frame <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IMG_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt;

    assign timeout_c = (state == DRAIN) && (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));

    // Drain watchdog: idle cycles since the last output beat.
    always_ff @(posedge axi_clock or posedge axi_reset) begin
        if (axi_reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if ((state != DRAIN) || out_beat || timeout_c) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + TIMEOUT_W'(1);
            end
            if (timeout_c) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

endmodule
